// File: rtl/countdown_timer_if.sv
// Control and display bundle for the BCD MM:SS countdown timer.
// The master side drives requests and the slave side drives the digits and status flags.
interface countdown_timer_if;
    logic       Tick;
    logic       Load;
    logic [7:0] LoadMin;
    logic [7:0] LoadSec;
    logic       StartStop;
    logic [3:0] MinH;
    logic [3:0] MinL;
    logic [3:0] SecH;
    logic [3:0] SecL;
    logic       Running;
    logic       Done;
    logic       Alarm;
    logic       Err;

    modport master (
        output Tick, Load, LoadMin, LoadSec, StartStop,
        input  MinH, MinL, SecH, SecL, Running, Done, Alarm, Err
    );

    modport slave (
        input  Tick, Load, LoadMin, LoadSec, StartStop,
        output MinH, MinL, SecH, SecL, Running, Done, Alarm, Err
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD minutes:seconds down-counter with run/pause control and an expiry alarm.
// Every output is taken directly from a register or decoded from the registered state.
module countdown_timer #(
    parameter int unsigned ALARM_LEN = 4
) (
    input logic              CP,
    input logic              nCR,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

    state_e     state_q, state_d;
    logic [3:0] min_h_q, min_h_d;
    logic [3:0] min_l_q, min_l_d;
    logic [3:0] sec_h_q, sec_h_d;
    logic [3:0] sec_l_q, sec_l_d;
    logic [7:0] alarm_cnt_q, alarm_cnt_d;
    logic       err_q, err_d;

    logic       load_valid;
    logic       count_zero;
    logic [3:0] dec_min_h, dec_min_l, dec_sec_h, dec_sec_l;
    logic       dec_zero;

    assign load_valid = (bus.LoadSec[3:0] <= 4'd9) && (bus.LoadSec[7:4] <= 4'd5) &&
                        (bus.LoadMin[3:0] <= 4'd9) && (bus.LoadMin[7:4] <= 4'd9);

    assign count_zero = (min_h_q == 4'd0) && (min_l_q == 4'd0) &&
                        (sec_h_q == 4'd0) && (sec_l_q == 4'd0);

    // One-second decrement with borrow rippling from seconds units up to minutes tens.
    always_comb begin
        dec_sec_l = sec_l_q;
        dec_sec_h = sec_h_q;
        dec_min_l = min_l_q;
        dec_min_h = min_h_q;
        if (sec_l_q != 4'd0) begin
            dec_sec_l = sec_l_q - 4'd1;
        end else begin
            dec_sec_l = 4'd9;
            if (sec_h_q != 4'd0) begin
                dec_sec_h = sec_h_q - 4'd1;
            end else begin
                dec_sec_h = 4'd5;
                if (min_l_q != 4'd0) begin
                    dec_min_l = min_l_q - 4'd1;
                end else begin
                    // RUN is never entered at 00:00, so MinH is nonzero here.
                    dec_min_l = 4'd9;
                    dec_min_h = min_h_q - 4'd1;
                end
            end
        end
        dec_zero = (dec_min_h == 4'd0) && (dec_min_l == 4'd0) &&
                   (dec_sec_h == 4'd0) && (dec_sec_l == 4'd0);
    end

    // Next-state logic: Load outside RUN takes priority and suppresses StartStop/Tick.
    always_comb begin
        state_d     = state_q;
        min_h_d     = min_h_q;
        min_l_d     = min_l_q;
        sec_h_d     = sec_h_q;
        sec_l_d     = sec_l_q;
        err_d       = 1'b0;
        alarm_cnt_d = (alarm_cnt_q != 8'd0) ? alarm_cnt_q - 8'd1 : 8'd0;

        if (bus.Load && (state_q != StRun)) begin
            if (load_valid) begin
                min_h_d     = bus.LoadMin[7:4];
                min_l_d     = bus.LoadMin[3:0];
                sec_h_d     = bus.LoadSec[7:4];
                sec_l_d     = bus.LoadSec[3:0];
                state_d     = StIdle;
                alarm_cnt_d = 8'd0;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.StartStop && !count_zero) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (bus.StartStop) begin
                        state_d = StPause;
                    end else if (bus.Tick) begin
                        min_h_d = dec_min_h;
                        min_l_d = dec_min_l;
                        sec_h_d = dec_sec_h;
                        sec_l_d = dec_sec_l;
                        if (dec_zero) begin
                            state_d     = StExpired;
                            alarm_cnt_d = 8'(ALARM_LEN);
                        end
                    end
                end
                StPause: begin
                    if (bus.StartStop) begin
                        state_d = StRun;
                    end
                end
                StExpired: begin
                    state_d = StExpired;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State, digit, alarm and error registers.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q     <= StIdle;
            min_h_q     <= 4'd0;
            min_l_q     <= 4'd0;
            sec_h_q     <= 4'd0;
            sec_l_q     <= 4'd0;
            alarm_cnt_q <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_h_q     <= min_h_d;
            min_l_q     <= min_l_d;
            sec_h_q     <= sec_h_d;
            sec_l_q     <= sec_l_d;
            alarm_cnt_q <= alarm_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.MinH    = min_h_q;
    assign bus.MinL    = min_l_q;
    assign bus.SecH    = sec_h_q;
    assign bus.SecL    = sec_l_q;
    assign bus.Running = (state_q == StRun);
    assign bus.Done    = (state_q == StExpired);
    assign bus.Alarm   = (alarm_cnt_q != 8'd0);
    assign bus.Err     = err_q;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD minutes:seconds down-counter for the digital clock: the count-down counterpart of the clock's up-counting mod-6/mod-10 digit chain. It is loaded with an MM:SS value, decrements once per 1 Hz enable pulse with borrow propagation between digits, and raises an alarm when it reaches 00:00. It sits beside the time-of-day counter chain and drives the same four-digit display mux.

## Interface
- ALARM_LEN, default 4: number of CP cycles Alarm stays high on expiry (1..255).
- CP  input  1  system clock, all state changes on rising edge.
- nCR  input  1  reset, asynchronous, active-low; clears all state immediately.
- Tick  input  1  1 Hz enable pulse, one CP cycle wide.
- Load  input  1  load request, one-cycle pulse.
- LoadMin  input  8  BCD minutes to load: [7:4] tens, [3:0] units.
- LoadSec  input  8  BCD seconds to load: [7:4] tens, [3:0] units.
- StartStop  input  1  run/pause toggle, one-cycle pulse.
- MinH, MinL, SecH, SecL  output  4 each  current BCD digits.
- Running  output  1  high in RUN.
- Done  output  1  high in EXPIRED.
- Alarm  output  1  expiry pulse, ALARM_LEN cycles.
- Err  output  1  one-cycle pulse on a rejected load.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset: state IDLE, all digits 0, Running/Done/Alarm/Err 0.
- Load validity: SecL ≤ 9, SecH ≤ 5, MinL ≤ 9, MinH ≤ 9.
  - Invalid: digits and state unchanged; Err pulses one cycle.
- Load outcomes by state:
  - IDLE, PAUSE, EXPIRED: valid Load writes all four digits and sets state IDLE. This clears Done and cancels any remaining Alarm.
  - RUN: Load is ignored with no Err.
- StartStop transitions:
  - IDLE with count ≠ 00:00: go to RUN.
  - IDLE with count = 00:00: ignored.
  - RUN: go to PAUSE.
  - PAUSE: go to RUN.
  - EXPIRED: ignored.
- Decrement, in RUN on Tick only:
  - SecL 0 → 9 with borrow, else SecL − 1.
  - Borrow: SecH 0 → 5 with borrow, else SecH − 1.
  - Borrow: MinL 0 → 9 with borrow, else MinL − 1.
  - Borrow: MinH − 1.
  - Borrow never leaves MinH, because RUN is never entered at 00:00.
- Expiry: a Tick that produces 00:00 moves the state to EXPIRED, sets Done = 1 and starts Alarm.
  - Digits hold 00:00 in EXPIRED; further Ticks are ignored.
- Tick is ignored in IDLE, PAUSE and EXPIRED.
- Simultaneous events:
  - Load + StartStop in the same cycle: Load is evaluated alone and StartStop is dropped, even if the load is invalid.
  - StartStop + Tick in RUN: transition to PAUSE, no decrement.
  - StartStop + Tick in PAUSE: transition to RUN, no decrement on that edge.
- Reset mid-operation: nCR low forces reset values asynchronously in any state, including during an Alarm pulse.

## Timing
- All outputs are registered; every change is visible after the CP edge that samples the input (1-cycle latency).
- Running and Done are decoded from registered state, so they change on the same edge as the state.
- Alarm rises on the edge that writes 00:00 and stays high exactly ALARM_LEN cycles, unless cut short by Load or reset.
- Err is high only for the cycle after the edge that sampled the invalid Load.
- Tick must be one cycle wide. A wider Tick decrements once per high cycle; this is not guarded.

## Test plan
- Reset: drive nCR low asynchronously mid-cycle → all digits 0, state IDLE, all flags 0 before the next CP edge.
- Borrow chain: load 10:00, StartStop, one Tick → 09:59. Next Tick → 09:58.
- Expiry: load 00:02, start, two Ticks → 00:01, then 00:00. Done = 1; Alarm high for 4 cycles after the second Tick edge. A third Tick leaves the count at 00:00.
- Pause: load 01:00, start, Tick → 00:59. Pulse StartStop together with a Tick → PAUSE, still 00:59. Ticks while paused → no change. StartStop, then Tick → 00:58.
- Load rules:
  - Load 00:60 → Err pulse, digits unchanged.
  - Load 05:30 during RUN → ignored, no Err.
  - Load + StartStop in IDLE → loaded, stays IDLE.
  - StartStop at 00:00 → stays IDLE.
- Re-arm: while EXPIRED with Alarm active, load 00:05 → IDLE, Done = 0, Alarm = 0 on the next cycle.
